regfile_writeback_queue: RTL and testbench



---
 rtl/regfile_writeback_queue_pkg.sv | 20 ++
 rtl/regfile_writeback_queue_fwd_search.sv | 43 ++++
 rtl/regfile_writeback_queue.sv | 125 ++++++++++++
 tb/tb_regfile_writeback_queue.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_writeback_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared widths and the writeback entry type for the register
//               file writeback queue.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    // One queued writeback: destination register and the value to write.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/regfile_writeback_queue_fwd_search.sv
`default_nettype none
// ============================================================================
// Module      : wbq_fwd_search
// Description : Forwarding lookup for one read port. Scans the queued entries
//               from oldest to youngest so the youngest match is the one left
//               on the outputs. Register x0 never matches.
// Revision    : 1.0 - initial release
// ============================================================================
module wbq_fwd_search
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic [REG_ADDR_W-1:0]     i_ent_rd   [DEPTH],
    input  logic [XLEN-1:0]           i_ent_data [DEPTH],
    input  logic [DEPTH-1:0]          i_ent_valid,
    input  logic [$clog2(DEPTH)-1:0]  i_head,
    input  logic [REG_ADDR_W-1:0]     i_rs,
    output logic                      o_hit,
    output logic [XLEN-1:0]           o_data
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [c_PTR_W-1:0] w_idx;

    // Walk by age starting at the head; later (younger) matches overwrite earlier ones.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = i_head + c_PTR_W'(k);
            if (i_ent_valid[w_idx] && (i_ent_rd[w_idx] == i_rs) && (i_rs != '0)) begin
                o_hit  = 1'b1;
                o_data = i_ent_data[w_idx];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_writeback_queue.sv
`default_nettype none
// ============================================================================
// Module      : regfile_writeback_queue
// Description : Circular buffer between the writeback producers and the
//               register file write port. Drains one entry per cycle when the
//               register file enables a write, and offers forwarding of queued
//               values to both operand read ports.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_writeback_queue
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = regfile_pkg::XLEN
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic                  wb_valid,
    output logic                  wb_ready,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  rf_en,
    output logic [REG_ADDR_W-1:0] rd,
    output logic [XLEN-1:0]       write_data,
    output logic                  RegWrite,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    output logic                  fwd1_hit,
    output logic                  fwd2_hit,
    output logic [XLEN-1:0]       fwd1_data,
    output logic [XLEN-1:0]       fwd2_data,
    output logic                  empty,
    output logic                  full
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [REG_ADDR_W-1:0] r_rd   [DEPTH];
    logic [XLEN-1:0]       r_data [DEPTH];
    logic [c_PTR_W-1:0]    r_head;
    logic [c_PTR_W-1:0]    r_tail;
    logic [c_CNT_W-1:0]    r_count;

    logic                  w_push;
    logic                  w_pop;
    logic [DEPTH-1:0]      w_valid;

    // Status comes from the count only, so head==tail is never ambiguous.
    assign full     = (r_count == c_CNT_W'(DEPTH));
    assign empty    = (r_count == '0);
    assign wb_ready = !full && !RST;
    assign RegWrite = !empty;

    // x0 results complete the handshake but are never stored.
    assign w_push = wb_valid && wb_ready && (wb_rd != '0);
    assign w_pop  = RegWrite && rf_en;

    assign rd         = empty ? '0 : r_rd[r_head];
    assign write_data = empty ? '0 : r_data[r_head];

    // An entry is live when its distance from the head is below the count.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
        logic [c_PTR_W-1:0] w_off;
        assign w_off       = c_PTR_W'(gi) - r_head;
        assign w_valid[gi] = ({1'b0, w_off} < r_count);
    end

    // Entry payload is written at the tail; liveness is tracked by the count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_rd[r_tail]   <= wb_rd;
            r_data[r_tail] <= wb_data;
        end
    end

    // Pointer and occupancy update; reset discards every queued entry.
    always_ff @(posedge clk) begin
        if (RST) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    wbq_fwd_search #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN)
    ) u_fwd1 (
        .i_ent_rd    (r_rd),
        .i_ent_data  (r_data),
        .i_ent_valid (w_valid),
        .i_head      (r_head),
        .i_rs        (rs1),
        .o_hit       (fwd1_hit),
        .o_data      (fwd1_data)
    );

    wbq_fwd_search #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN)
    ) u_fwd2 (
        .i_ent_rd    (r_rd),
        .i_ent_data  (r_data),
        .i_ent_valid (w_valid),
        .i_head      (r_head),
        .i_rs        (rs2),
        .o_hit       (fwd2_hit),
        .o_data      (fwd2_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_writeback_queue
// Description : Self-checking bench for the writeback queue: directed corner
//               sequences, a forwarding vector table and randomized traffic
//               against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_writeback_queue;
    import regfile_pkg::*;

    localparam int c_DEPTH = 4;

    logic        clk = 1'b0;
    logic        RST;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        rf_en;
    logic [4:0]  rd;
    logic [31:0] write_data;
    logic        RegWrite;
    logic [4:0]  rs1, rs2;
    logic        fwd1_hit, fwd2_hit;
    logic [31:0] fwd1_data, fwd2_data;
    logic        empty, full;

    int total = 0;
    int bad   = 0;

    wb_entry_t mq[$];          // reference queue, index 0 is the oldest
    wb_entry_t m_commits[$];   // writes the model expects the register file to see
    wb_entry_t d_commits[$];   // writes observed on the DUT write port

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        h1;
        logic [31:0] d1;
        logic        h2;
        logic [31:0] d2;
    } fwd_vec_t;

    fwd_vec_t vecs[5];

    regfile_writeback_queue #(.DEPTH(c_DEPTH), .XLEN(32)) dut (
        .clk        (clk),
        .RST        (RST),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .rf_en      (rf_en),
        .rd         (rd),
        .write_data (write_data),
        .RegWrite   (RegWrite),
        .rs1        (rs1),
        .rs2        (rs2),
        .fwd1_hit   (fwd1_hit),
        .fwd2_hit   (fwd2_hit),
        .fwd1_data  (fwd1_data),
        .fwd2_data  (fwd2_data),
        .empty      (empty),
        .full       (full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void mfwd(input logic [4:0] rs, output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d   = '0;
        if (rs != 0) begin
            foreach (mq[i]) begin
                if (mq[i].rd == rs) begin
                    hit = 1'b1;
                    d   = mq[i].data;
                end
            end
        end
    endfunction

    task automatic check_all();
        logic        h;
        logic [31:0] d;
        chk("regwrite",   RegWrite,   mq.size() > 0);
        chk("rd",         rd,         (mq.size() > 0) ? mq[0].rd : 5'd0);
        chk("write_data", write_data, (mq.size() > 0) ? mq[0].data : 32'd0);
        chk("empty",      empty,      mq.size() == 0);
        chk("full",       full,       mq.size() == c_DEPTH);
        chk("wb_ready",   wb_ready,   (mq.size() < c_DEPTH) && !RST);
        mfwd(rs1, h, d);
        chk("fwd1_hit",  fwd1_hit,  h);
        chk("fwd1_data", fwd1_data, d);
        mfwd(rs2, h, d);
        chk("fwd2_hit",  fwd2_hit,  h);
        chk("fwd2_data", fwd2_data, d);
    endtask

    // Check outputs against the model, then advance model and DUT by one edge.
    task automatic tick();
        bit        pop, push;
        wb_entry_t e;
        #1;
        check_all();
        if (!RST && RegWrite && rf_en) begin
            e.rd = rd; e.data = write_data;
            d_commits.push_back(e);
        end
        pop  = (mq.size() > 0) && rf_en;
        push = wb_valid && (mq.size() < c_DEPTH) && (wb_rd != 0);
        if (RST) begin
            mq.delete();
        end else begin
            if (pop) begin
                m_commits.push_back(mq[0]);
                void'(mq.pop_front());
            end
            if (push) begin
                e.rd = wb_rd; e.data = wb_data;
                mq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_valid = 0; wb_rd = 0; wb_data = 0; rf_en = 0; rs1 = 0; rs2 = 0;
    endtask

    task automatic do_reset();
        RST = 1; idle_inputs();
        tick();
        RST = 0;
        m_commits.delete();
        d_commits.delete();
    endtask

    task automatic push_one(input logic [4:0] r, input logic [31:0] d, input logic en);
        wb_valid = 1; wb_rd = r; wb_data = d; rf_en = en;
        tick();
        wb_valid = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        RST = 1; idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        mq.delete();

        // Reset state
        do_reset();
        #1;
        chk("rst_regwrite", RegWrite, 0);
        chk("rst_empty",    empty,    1);
        chk("rst_full",     full,     0);
        chk("rst_wdata",    write_data, 0);

        // Fill and drain
        push_one(5, 32'h11, 0);
        push_one(6, 32'h22, 0);
        push_one(7, 32'h33, 0);
        push_one(8, 32'h44, 0);
        wb_valid = 1; wb_rd = 9; wb_data = 32'h99; rf_en = 0;
        #1;
        chk("fill_full",  full,     1);
        chk("fill_ready", wb_ready, 0);
        chk("fill_rd",    rd,       5);
        tick();
        chk("fill_rd_held", rd, 5);
        wb_valid = 0; rf_en = 1;
        repeat (4) tick();
        chk("drain_empty",    empty,    1);
        chk("drain_regwrite", RegWrite, 0);
        chk("drain_count", d_commits.size(), 4);
        for (int i = 0; i < 4 && i < d_commits.size(); i++) begin
            chk("drain_rd",   d_commits[i].rd,   5 + i);
            chk("drain_data", d_commits[i].data, 32'h11 * (i + 1));
        end

        // x0 drop
        rf_en = 0;
        wb_valid = 1; wb_rd = 0; wb_data = 32'hDEAD;
        #1;
        chk("x0_ready", wb_ready, 1);
        tick();
        wb_valid = 0;
        chk("x0_empty",    empty,    1);
        chk("x0_regwrite", RegWrite, 0);

        // Youngest-wins forwarding, table driven
        do_reset();
        push_one(3, 32'hA, 0);
        push_one(3, 32'hB, 0);
        push_one(7, 32'h77, 0);
        vecs[0] = '{rs1: 3, rs2: 4, h1: 1, d1: 32'hB,  h2: 0, d2: 0};
        vecs[1] = '{rs1: 0, rs2: 7, h1: 0, d1: 0,      h2: 1, d2: 32'h77};
        vecs[2] = '{rs1: 7, rs2: 3, h1: 1, d1: 32'h77, h2: 1, d2: 32'hB};
        vecs[3] = '{rs1: 0, rs2: 0, h1: 0, d1: 0,      h2: 0, d2: 0};
        vecs[4] = '{rs1: 31, rs2: 5, h1: 0, d1: 0,     h2: 0, d2: 0};
        foreach (vecs[i]) begin
            rs1 = vecs[i].rs1; rs2 = vecs[i].rs2;
            #1;
            chk("vec_h1", fwd1_hit,  vecs[i].h1);
            chk("vec_d1", fwd1_data, vecs[i].d1);
            chk("vec_h2", fwd2_hit,  vecs[i].h2);
            chk("vec_d2", fwd2_data, vecs[i].d2);
        end
        // Head stays searchable until its pop edge, then drops out.
        rs1 = 3; rf_en = 1;
        tick();
        chk("fwd_after_pop_hit",  fwd1_hit,  1);
        chk("fwd_after_pop_data", fwd1_data, 32'hB);
        tick();
        chk("fwd_gone_hit", fwd1_hit, 0);
        rf_en = 0; rs1 = 0;

        // Simultaneous push/pop at steady state
        do_reset();
        push_one(10, 32'h100, 0);
        for (int i = 0; i < 10; i++) begin
            wb_valid = 1; wb_rd = 5'(11 + i); wb_data = 32'h200 + i; rf_en = 1;
            tick();
            chk("steady_regwrite", RegWrite, 1);
            chk("steady_full",     full,     0);
        end
        wb_valid = 0; rf_en = 0;
        chk("steady_commits", d_commits.size(), 10);
        for (int i = 0; i < d_commits.size(); i++) begin
            chk("steady_rd", d_commits[i].rd, 10 + i);
        end

        // Reset mid-operation
        do_reset();
        push_one(1, 32'h1, 0);
        push_one(2, 32'h2, 0);
        push_one(4, 32'h4, 0);
        RST = 1;
        tick();
        RST = 0; rs1 = 1; rs2 = 4;
        #1;
        chk("midrst_regwrite", RegWrite, 0);
        chk("midrst_empty",    empty,    1);
        chk("midrst_fwd1",     fwd1_hit, 0);
        chk("midrst_fwd2",     fwd2_hit, 0);
        rf_en = 1;
        tick();
        chk("midrst_commits", d_commits.size(), 0);

        // Randomized traffic against the reference model
        do_reset();
        for (int n = 0; n < 400; n++) begin
            RST      = ($urandom_range(0, 59) == 0);
            wb_valid = ($urandom_range(0, 3) != 0);
            wb_rd    = 5'($urandom_range(0, 7));
            wb_data  = $urandom;
            rf_en    = $urandom_range(0, 1) == 1;
            rs1      = 5'($urandom_range(0, 7));
            rs2      = 5'($urandom_range(0, 7));
            tick();
        end
        RST = 0; idle_inputs();
        chk("rand_commit_count", d_commits.size(), m_commits.size());
        for (int i = 0; i < d_commits.size() && i < m_commits.size(); i++) begin
            chk("rand_commit", {d_commits[i].rd, d_commits[i].data}, {m_commits[i].rd, m_commits[i].data});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
